// File: rtl/board_render_pkg.sv
// Shared constants and types for the board pixel renderer (640x480@60 scan-out of a 12x10 RGB332 board).
package board_render_pkg;

    localparam int unsigned H_VISIBLE  = 640;
    localparam int unsigned H_FP       = 16;
    localparam int unsigned H_SYNC     = 96;
    localparam int unsigned H_BP       = 48;
    localparam int unsigned V_VISIBLE  = 480;
    localparam int unsigned V_FP       = 10;
    localparam int unsigned V_SYNC     = 2;
    localparam int unsigned V_BP       = 33;

    localparam int unsigned BOARD_ROWS = 12;
    localparam int unsigned BOARD_COLS = 10;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned ROW_W      = 4;
    localparam int unsigned COL_W      = 4;

    typedef logic [7:0]       rgb332_t;
    typedef logic [0:79]      color_row_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Stage-1 cell lookup payload
    typedef struct packed {
        logic             in_board;
        logic             grid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cell_sel_t;

    function automatic cnt_t to_cnt(input int unsigned v);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters plus raw sync/de/frame_start registered one stage after the counters.
module vga_timing_gen
    import board_render_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_VISIBLE,
    parameter int unsigned H_FRONT  = H_FP,
    parameter int unsigned H_SYNC_W = H_SYNC,
    parameter int unsigned H_BACK   = H_BP,
    parameter int unsigned V_ACTIVE = V_VISIBLE,
    parameter int unsigned V_FRONT  = V_FP,
    parameter int unsigned V_SYNC_W = V_SYNC,
    parameter int unsigned V_BACK   = V_BP
) (
    input  logic clk,
    input  logic rst_n,
    output cnt_t h_cnt_o,
    output cnt_t v_cnt_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic de_o,
    output logic frame_start_o
);

    localparam cnt_t H_LAST   = to_cnt(H_ACTIVE + H_FRONT + H_SYNC_W + H_BACK - 1);
    localparam cnt_t V_LAST   = to_cnt(V_ACTIVE + V_FRONT + V_SYNC_W + V_BACK - 1);
    localparam cnt_t HS_FIRST = to_cnt(H_ACTIVE + H_FRONT);
    localparam cnt_t HS_LAST  = to_cnt(H_ACTIVE + H_FRONT + H_SYNC_W - 1);
    localparam cnt_t VS_FIRST = to_cnt(V_ACTIVE + V_FRONT);
    localparam cnt_t VS_LAST  = to_cnt(V_ACTIVE + V_FRONT + V_SYNC_W - 1);
    localparam cnt_t H_VIS    = to_cnt(H_ACTIVE);
    localparam cnt_t V_VIS    = to_cnt(V_ACTIVE);

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic hsync_q, vsync_q, de_q, frame_start_q;
    logic hsync_raw, vsync_raw, de_raw, fs_raw;

    // Counter advance with line and frame wrap
    always_comb begin
        h_cnt_d = h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
        end
    end

    always_comb begin
        hsync_raw = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync_raw = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        de_raw    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        fs_raw    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_raw;
            vsync_q       <= vsync_raw;
            de_q          <= de_raw;
            frame_start_q <= fs_raw;
        end
    end

    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/board_pixel_renderer.sv
// Scans a per-frame snapshot of the 12x10 board colour map out as a VGA pixel stream.
// Optional grid overlay is enabled by defining BOARD_GRID_EN.
module board_pixel_renderer
    import board_render_pkg::*;
#(
    parameter int unsigned CELL_PX    = 32,
    parameter int unsigned X0         = 160,
    parameter int unsigned Y0         = 48,
    parameter rgb332_t     BG_COLOR   = 8'h00,
    parameter rgb332_t     GRID_COLOR = 8'h49,
    parameter int unsigned H_ACTIVE   = H_VISIBLE,
    parameter int unsigned H_FRONT    = H_FP,
    parameter int unsigned H_SYNC_W   = H_SYNC,
    parameter int unsigned H_BACK     = H_BP,
    parameter int unsigned V_ACTIVE   = V_VISIBLE,
    parameter int unsigned V_FRONT    = V_FP,
    parameter int unsigned V_SYNC_W   = V_SYNC,
    parameter int unsigned V_BACK     = V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  color_row_t color_values [0:BOARD_ROWS-1],
    output rgb332_t    pixel,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start
);

    localparam int unsigned CELL_LOG2 = $clog2(CELL_PX);
    localparam cnt_t BX_LO = to_cnt(X0);
    localparam cnt_t BX_HI = to_cnt(X0 + BOARD_COLS * CELL_PX);
    localparam cnt_t BY_LO = to_cnt(Y0);
    localparam cnt_t BY_HI = to_cnt(Y0 + BOARD_ROWS * CELL_PX);
    localparam cnt_t CAP_V = to_cnt(V_ACTIVE);

    cnt_t      h_cnt, v_cnt, h_off_c, v_off_c;
    logic      hsync_s1, vsync_s1, de_s1, fs_s1;
    logic      in_board_c, capture_c;
    cell_sel_t sel_d, sel_q;
    rgb332_t   cell_c, pixel_d;
    rgb332_t   pixel_q;
    logic      hsync_q, vsync_q, de_q, frame_start_q;
    color_row_t snap_q [0:BOARD_ROWS-1];

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC_W (H_SYNC_W), .H_BACK (H_BACK),
        .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC_W (V_SYNC_W), .V_BACK (V_BACK)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .hsync_o       (hsync_s1),
        .vsync_o       (vsync_s1),
        .de_o          (de_s1),
        .frame_start_o (fs_s1)
    );

    // Tear-free capture at the first pixel of vertical blanking
    assign capture_c = (h_cnt == '0) && (v_cnt == CAP_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '{default: '0};
        end else if (capture_c) begin
            snap_q <= color_values;
        end
    end

    // Stage 1: board hit test and cell index, only meaningful inside the board
    always_comb begin
        sel_d      = '0;
        h_off_c    = h_cnt - BX_LO;
        v_off_c    = v_cnt - BY_LO;
        in_board_c = (h_cnt >= BX_LO) && (h_cnt < BX_HI) && (v_cnt >= BY_LO) && (v_cnt < BY_HI);
        if (in_board_c) begin
            sel_d.in_board = 1'b1;
            sel_d.col      = COL_W'(h_off_c >> CELL_LOG2);
            sel_d.row      = ROW_W'(v_off_c >> CELL_LOG2);
        end
`ifdef BOARD_GRID_EN
        sel_d.grid = (in_board_c && ((h_off_c[CELL_LOG2-1:0] == '0) || (v_off_c[CELL_LOG2-1:0] == '0)))
                  || ((h_cnt == BX_HI) && (v_cnt >= BY_LO) && (v_cnt <= BY_HI))
                  || ((v_cnt == BY_HI) && (h_cnt >= BX_LO) && (h_cnt <= BX_HI));
`else
        sel_d.grid = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Stage 2: colour select; blanking forces black regardless of selection
    always_comb begin
        cell_c  = snap_q[sel_q.row][{sel_q.col, 3'b000} +: 8];
        pixel_d = BG_COLOR;
        if (sel_q.grid) begin
            pixel_d = GRID_COLOR;
        end else if (sel_q.in_board) begin
            pixel_d = cell_c;
        end
        if (!de_s1) begin
            pixel_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_q       <= pixel_d;
            hsync_q       <= hsync_s1;
            vsync_q       <= vsync_s1;
            de_q          <= de_s1;
            frame_start_q <= fs_s1;
        end
    end

    assign pixel       = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_board_pixel_renderer.sv
// Scoreboard bench for board_pixel_renderer using a shrunken raster so several frames fit in a short run.
module tb_board_pixel_renderer;
    import board_render_pkg::*;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 56, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CELL = 4, X0 = 16, Y0 = 4;
    localparam logic [7:0] BG = 8'h03, GRID = 8'h49;
`ifdef BOARD_GRID_EN
    localparam bit GRID_ON = 1'b1;
`else
    localparam bit GRID_ON = 1'b0;
`endif
    localparam int PX = 0, HSY = 1, VSY = 2, DEN = 3, FST = 4;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] exp_v;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    color_row_t cv [0:BOARD_ROWS-1];
    rgb332_t    px;
    logic       hs, vs, de_w, fs;
    int         cyc;
    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];

    board_pixel_renderer #(
        .CELL_PX (CELL), .X0 (X0), .Y0 (Y0), .BG_COLOR (BG), .GRID_COLOR (GRID),
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC_W (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC_W (VS), .V_BACK (VB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .color_values (cv),
        .pixel        (px),
        .hsync        (hs),
        .vsync        (vs),
        .de           (de_w),
        .frame_start  (fs)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int pcyc(input int x, input int y, input int f);
        return f * FRAME + y * HT + x + 2;
    endfunction

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            PX:      return px;
            HSY:     return 8'(hs);
            VSY:     return 8'(vs);
            DEN:     return 8'(de_w);
            default: return 8'(fs);
        endcase
    endfunction

    task automatic push(input int c, input int sig, input logic [7:0] e, input string tag);
        exp_t item;
        int   i;
        item.cyc = c; item.sig = sig; item.exp_v = e; item.tag = tag;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, item);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $error("FAIL %s missed at cycle %0d (now %0d)", e.tag, e.cyc, cyc);
            end else begin
                check(e.tag, observe(e.sig), e.exp_v);
            end
        end
    endtask

    task automatic run_until(input int target);
        while (cyc < target) begin
            @(negedge clk);
            drain();
        end
    endtask

    initial begin
        for (int r = 0; r < 12; r++) cv[r] = '0;
        cv[0][0*8 +: 8]  = 8'hF0;
        cv[11][9*8 +: 8] = 8'h7F;
        cv[5][3*8 +: 8]  = 8'h92;

        // Held reset
        repeat (10) @(negedge clk);
        check("rst_px", px, 8'h00);
        check("rst_hs", 8'(hs), 8'h01);
        check("rst_vs", 8'(vs), 8'h01);
        check("rst_de", 8'(de_w), 8'h00);
        check("rst_fs", 8'(fs), 8'h00);
        rst_n = 1'b1;

        // First frame: latency, sync shapes, black board
        push(1, FST, 8'h00, "fs_pre");
        push(1, DEN, 8'h00, "de_pre");
        push(2, FST, 8'h01, "fs_first");
        push(2, DEN, 8'h01, "de_first");
        push(pcyc(0, 0, 0), PX, BG, "px_bg_origin");
        push(pcyc(X0 + 1, Y0 + 1, 0), PX, 8'h00, "px_black_frame0");
        push(pcyc(HA, 3, 0), DEN, 8'h00, "de_hblank");
        push(pcyc(HA + 1, 3, 0), PX, 8'h00, "px_hblank");
        push(pcyc(HA + HF - 1, 3, 0), HSY, 8'h01, "hs_before");
        push(pcyc(HA + HF, 3, 0), HSY, 8'h00, "hs_first");
        push(pcyc(HA + HF + HS - 1, 3, 0), HSY, 8'h00, "hs_last");
        push(pcyc(HA + HF + HS, 3, 0), HSY, 8'h01, "hs_after");
        push(pcyc(HT - 1, VA + VF - 1, 0), VSY, 8'h01, "vs_before");
        push(pcyc(0, VA + VF, 0), VSY, 8'h00, "vs_first");
        push(pcyc(HT - 1, VA + VF + 1, 0), VSY, 8'h00, "vs_last");
        push(pcyc(0, VA + VF + 2, 0), VSY, 8'h01, "vs_after");
        push(pcyc(0, 0, 1) - 1, FST, 8'h00, "fs_gap");
        push(pcyc(0, 0, 1), FST, 8'h01, "fs_period");
        push(pcyc(0, 0, 1) + 1, FST, 8'h00, "fs_single");

        // Second frame: captured colours and board boundaries
        push(pcyc(X0 + 1, Y0 + 1, 1), PX, 8'hF0, "px_cell00");
        push(pcyc(X0 - 1, Y0, 1), PX, BG, "px_left_of_board");
        push(pcyc(X0 + CELL - 1, Y0 + CELL - 1, 1), PX, 8'hF0, "px_cell00_corner");
        push(pcyc(X0 + CELL + 1, Y0 + 1, 1), PX, 8'h00, "px_cell01");
        push(pcyc(X0 + 10 * CELL - 1, Y0 + 12 * CELL - 1, 1), PX, 8'h7F, "px_cell_11_9");
        push(pcyc(X0, Y0, 1), PX, GRID_ON ? GRID : 8'hF0, "px_board_origin");
        push(pcyc(X0 + CELL, Y0 + 3, 1), PX, GRID_ON ? GRID : 8'h00, "px_col_edge");
        push(pcyc(X0 + 2, Y0 + CELL, 1), PX, GRID_ON ? GRID : 8'h00, "px_row_edge");
        push(pcyc(X0 + 10 * CELL, Y0 + 5, 1), PX, GRID_ON ? GRID : BG, "px_right_edge");
        push(pcyc(X0 + 5, Y0 + 12 * CELL, 1), PX, GRID_ON ? GRID : BG, "px_bottom_edge");
        push(pcyc(HA + 1, Y0 + 1, 1), PX, 8'h00, "px_blank_forced");
        push(pcyc(X0 + 3 * CELL + 1, Y0 + 5 * CELL + 1, 1), PX, 8'h92, "px_flash_hold");
        run_until(pcyc(0, 10, 1));

        // Mid-frame colour change is invisible until the next capture
        cv[5][3*8 +: 8] = 8'h1C;
        push(pcyc(X0 + 3 * CELL + 2, Y0 + 5 * CELL + 2, 1), PX, 8'h92, "px_tear_free");
        push(pcyc(X0 + 3 * CELL + 1, Y0 + 5 * CELL + 1, 2), PX, 8'h1C, "px_new_colour");
        push(pcyc(X0 + 10 * CELL - 1, Y0 + 12 * CELL - 1, 2), PX, 8'h7F, "px_pre_reset");
        run_until(pcyc(X0 + 10 * CELL - 1, Y0 + 12 * CELL - 1, 2));

        // Asynchronous reset mid-frame
        #1 rst_n = 1'b0;
        #1;
        check("async_px", px, 8'h00);
        check("async_de", 8'(de_w), 8'h00);
        check("async_hs", 8'(hs), 8'h01);
        check("async_vs", 8'(vs), 8'h01);
        check("async_fs", 8'(fs), 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        push(2, FST, 8'h01, "fs_after_reset");
        push(pcyc(X0 + 3 * CELL + 1, Y0 + 5 * CELL + 1, 0), PX, 8'h00, "px_snap_cleared");
        push(pcyc(X0 + 1, Y0 + 1, 0), PX, 8'h00, "px_cell00_cleared");
        push(pcyc(X0 + 3 * CELL + 1, Y0 + 5 * CELL + 1, 1), PX, 8'h1C, "px_recapture");
        push(pcyc(X0 + 1, Y0 + 1, 1), PX, 8'hF0, "px_cell00_recapture");
        run_until(pcyc(HT - 1, VT - 1, 1));

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $error("FAIL %s never reached (cycle %0d)", e.tag, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
